// File: rtl/llc_chan_sched.sv
// llc_chan_sched: input-channel scheduler in front of the LLC datapath.
// Arbitrates L2 responses, coherence requests and DMA beats onto a single
// registered grant slot and keeps a small set-lock table so that no two
// in-flight requests target the same LLC set. DMA bursts stay contiguous.
// Optional feature: define LLC_SCHED_STATS_EN to add the 16-bit stall_cnt
// output counting cycles lost to set conflicts or a full lock table.
module llc_chan_sched #(
  parameter int SET_W  = 9,
  parameter int N_LOCK = 4,
  parameter int LOCK_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rsp_in_valid,
  input  logic [SET_W-1:0]  rsp_in_set,
  output logic              rsp_in_ready,
  input  logic              req_in_valid,
  input  logic [SET_W-1:0]  req_in_set,
  output logic              req_in_ready,
  input  logic              dma_in_valid,
  input  logic [SET_W-1:0]  dma_in_set,
  input  logic              dma_in_last,
  output logic              dma_in_ready,
  output logic              sel_valid,
  output logic [1:0]        sel_ch,
  output logic [SET_W-1:0]  sel_set,
  output logic [LOCK_W-1:0] sel_lock_idx,
  input  logic              sel_ready,
  input  logic              done_valid,
  input  logic [LOCK_W-1:0] done_idx
`ifdef LLC_SCHED_STATS_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  localparam logic [1:0] CH_RSP = 2'b01;
  localparam logic [1:0] CH_REQ = 2'b10;
  localparam logic [1:0] CH_DMA = 2'b11;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  // Round-robin pointer: names the channel favoured on a req/dma tie.
  localparam logic RR_REQ = 1'b0;
  localparam logic RR_DMA = 1'b1;

  logic [0:0]                   state_q, state_d;
  logic                         rr_q, rr_d;
  logic [LOCK_W-1:0]            held_idx_q, held_idx_d;
  logic [N_LOCK-1:0]            lock_vld_q, lock_vld_d;
  logic [N_LOCK-1:0][SET_W-1:0] lock_set_q, lock_set_d;

  logic              sel_valid_q, sel_valid_d;
  logic [1:0]        sel_ch_q, sel_ch_d;
  logic [SET_W-1:0]  sel_set_q, sel_set_d;
  logic [LOCK_W-1:0] sel_idx_q, sel_idx_d;

  logic              free_any;
  logic [LOCK_W-1:0] free_idx;
  logic              req_hit, dma_hit;
  logic              in_burst;
  logic              req_elig, dma_elig;
  logic              load, pick_dma;
  logic              gnt_rsp, gnt_req, gnt_dma;
  logic [LOCK_W-1:0] dma_idx;

  assign in_burst = (state_q == ST_BURST);

  // Lock table lookup: lowest free entry and set-conflict detection.
  // During a burst the held entry belongs to the DMA stream itself and is
  // excluded from the DMA conflict check.
  always_comb begin
    free_any = 1'b0;
    free_idx = '0;
    req_hit  = 1'b0;
    dma_hit  = 1'b0;
    for (int i = N_LOCK - 1; i >= 0; i--) begin
      if (!lock_vld_q[i]) begin
        free_any = 1'b1;
        free_idx = LOCK_W'(i);
      end
      if (lock_vld_q[i] && (lock_set_q[i] == req_in_set))
        req_hit = 1'b1;
      if (lock_vld_q[i] && (lock_set_q[i] == dma_in_set) &&
          !(in_burst && (LOCK_W'(i) == held_idx_q)))
        dma_hit = 1'b1;
    end
  end

  // The table is looked at before this cycle's release, so a done and a
  // grant to the same set in one cycle leaves the grant blocked.
  assign req_elig = req_in_valid & free_any & ~req_hit & ~in_burst;
  assign dma_elig = dma_in_valid & free_any & ~dma_hit;

  // Slot loads when empty or being drained; gated by reset so no ready
  // pulse escapes while rst is asserted.
  assign load     = rst & (~sel_valid_q | sel_ready);
  assign pick_dma = dma_elig & (~req_elig | (rr_q == RR_DMA));
  assign gnt_rsp  = load & rsp_in_valid;
  assign gnt_dma  = load & ~rsp_in_valid & pick_dma;
  assign gnt_req  = load & ~rsp_in_valid & req_elig & ~pick_dma;
  assign dma_idx  = in_burst ? held_idx_q : free_idx;

  assign rsp_in_ready = gnt_rsp;
  assign req_in_ready = gnt_req;
  assign dma_in_ready = gnt_dma;

  // Next state for slot, burst FSM and round-robin pointer.
  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    held_idx_d  = held_idx_q;
    sel_valid_d = sel_valid_q;
    sel_ch_d    = sel_ch_q;
    sel_set_d   = sel_set_q;
    sel_idx_d   = sel_idx_q;
    if (load) begin
      sel_valid_d = gnt_rsp | gnt_req | gnt_dma;
      if (gnt_rsp) begin
        sel_ch_d  = CH_RSP;
        sel_set_d = rsp_in_set;
        sel_idx_d = '0;
      end else if (gnt_req) begin
        sel_ch_d  = CH_REQ;
        sel_set_d = req_in_set;
        sel_idx_d = free_idx;
        rr_d      = RR_DMA;
      end else if (gnt_dma) begin
        sel_ch_d  = CH_DMA;
        sel_set_d = dma_in_set;
        sel_idx_d = dma_idx;
        rr_d      = RR_REQ;
        if (dma_in_last) begin
          state_d = ST_IDLE;
        end else begin
          state_d    = ST_BURST;
          held_idx_d = dma_idx;
        end
      end
    end
  end

  // Lock table update: release first so a same-cycle allocation wins.
  // Burst continuation beats reuse the held entry and leave the table alone.
  always_comb begin
    lock_vld_d = lock_vld_q;
    lock_set_d = lock_set_q;
    if (done_valid)
      lock_vld_d[done_idx] = 1'b0;
    if (gnt_req) begin
      lock_vld_d[free_idx] = 1'b1;
      lock_set_d[free_idx] = req_in_set;
    end else if (gnt_dma && !in_burst) begin
      lock_vld_d[free_idx] = 1'b1;
      lock_set_d[free_idx] = dma_in_set;
    end
  end

  // State registers; reset discards any burst or lock in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      rr_q        <= RR_REQ;
      held_idx_q  <= '0;
      lock_vld_q  <= '0;
      lock_set_q  <= '0;
      sel_valid_q <= 1'b0;
      sel_ch_q    <= '0;
      sel_set_q   <= '0;
      sel_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      held_idx_q  <= held_idx_d;
      lock_vld_q  <= lock_vld_d;
      lock_set_q  <= lock_set_d;
      sel_valid_q <= sel_valid_d;
      sel_ch_q    <= sel_ch_d;
      sel_set_q   <= sel_set_d;
      sel_idx_q   <= sel_idx_d;
    end
  end

  assign sel_valid    = sel_valid_q;
  assign sel_ch       = sel_ch_q;
  assign sel_set      = sel_set_q;
  assign sel_lock_idx = sel_idx_q;

`ifdef LLC_SCHED_STATS_EN
  logic        stall_hit;
  logic [15:0] stall_cnt_q;

  // A req during a burst is blocked by the FSM anyway, so it only counts
  // as a lock stall while idle.
  assign stall_hit = (req_in_valid & ~in_burst & (~free_any | req_hit)) |
                     (dma_in_valid & (~free_any | dma_hit));

  // Saturating count of cycles lost to set conflicts or a full table.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      stall_cnt_q <= '0;
    else if (stall_hit && (stall_cnt_q != 16'hFFFF))
      stall_cnt_q <= stall_cnt_q + 16'd1;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_llc_chan_sched.sv
// Self-checking bench for llc_chan_sched: directed scenarios with literal
// expectations followed by randomized traffic against a behavioural model.
module tb_llc_chan_sched;

  logic       clk;
  logic       rst;
  logic       rsp_in_valid, req_in_valid, dma_in_valid, dma_in_last;
  logic [8:0] rsp_in_set, req_in_set, dma_in_set;
  logic       rsp_in_ready, req_in_ready, dma_in_ready;
  logic       sel_valid;
  logic [1:0] sel_ch;
  logic [8:0] sel_set;
  logic [1:0] sel_lock_idx;
  logic       sel_ready, done_valid;
  logic [1:0] done_idx;
`ifdef LLC_SCHED_STATS_EN
  logic [15:0] stall_cnt;
`endif

  llc_chan_sched #(.SET_W(9), .N_LOCK(4), .LOCK_W(2)) dut (
    .clk(clk), .rst(rst),
    .rsp_in_valid(rsp_in_valid), .rsp_in_set(rsp_in_set), .rsp_in_ready(rsp_in_ready),
    .req_in_valid(req_in_valid), .req_in_set(req_in_set), .req_in_ready(req_in_ready),
    .dma_in_valid(dma_in_valid), .dma_in_set(dma_in_set), .dma_in_last(dma_in_last),
    .dma_in_ready(dma_in_ready),
    .sel_valid(sel_valid), .sel_ch(sel_ch), .sel_set(sel_set), .sel_lock_idx(sel_lock_idx),
    .sel_ready(sel_ready), .done_valid(done_valid), .done_idx(done_idx)
`ifdef LLC_SCHED_STATS_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: lock table as plain arrays, burst flag, favoured channel.
  bit       m_vld [4];
  int       m_set [4];
  bit       m_burst;
  int       m_held;
  int       m_fav;      // 2 = req favoured, 3 = dma favoured
  bit       m_sv;
  int       m_sch, m_sset, m_sidx;
  int       m_stall;

  bit       last_rsp, last_req, last_dma;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin m_vld[i] = 0; m_set[i] = 0; end
    m_burst = 0; m_held = 0; m_fav = 2;
    m_sv = 0; m_sch = 0; m_sset = 0; m_sidx = 0; m_stall = 0;
  endtask

  task automatic idle_inputs();
    rsp_in_valid = 0; req_in_valid = 0; dma_in_valid = 0; dma_in_last = 0;
    rsp_in_set = 0; req_in_set = 0; dma_in_set = 0;
    sel_ready = 1; done_valid = 0; done_idx = 0;
  endtask

  // Called at a negedge: asserts reset with traffic present, checks that every
  // output drops at once, then releases reset on the following negedge.
  task automatic do_reset();
    rst = 0;
    rsp_in_valid = 1; req_in_valid = 1; dma_in_valid = 1;
    rsp_in_set = 9'h7; req_in_set = 9'h8; dma_in_set = 9'h9;
    #1;
    chk("rst_sel_valid", sel_valid, 0);
    chk("rst_sel_ch", sel_ch, 0);
    chk("rst_sel_set", sel_set, 0);
    chk("rst_sel_idx", sel_lock_idx, 0);
    chk("rst_rsp_ready", rsp_in_ready, 0);
    chk("rst_req_ready", req_in_ready, 0);
    chk("rst_dma_ready", dma_in_ready, 0);
`ifdef LLC_SCHED_STATS_EN
    chk("rst_stall_cnt", stall_cnt, 0);
`endif
    @(posedge clk);
    @(negedge clk);
    model_reset();
    idle_inputs();
    rst = 1;
  endtask

  // One cycle: inputs are already driven (at the negedge). Compare the slot
  // and the ready pulses against the model, then advance the model at the edge.
  task automatic step();
    int  nfree, lf, g, alloc;
    bit  rhit, dhit, req_ok, dma_ok, can_load;
    bit  d_v; int d_i;
    #1;
    chk("sel_valid", sel_valid, m_sv);
    if (m_sv) begin
      chk("sel_ch", sel_ch, m_sch);
      chk("sel_set", sel_set, m_sset);
      chk("sel_lock_idx", sel_lock_idx, m_sidx);
    end
`ifdef LLC_SCHED_STATS_EN
    chk("stall_cnt", stall_cnt, m_stall);
`endif
    nfree = 0; lf = -1; rhit = 0; dhit = 0;
    for (int i = 0; i < 4; i++) begin
      if (!m_vld[i]) begin
        nfree++;
        if (lf < 0) lf = i;
      end else begin
        if (m_set[i] == int'(req_in_set)) rhit = 1;
        if (m_set[i] == int'(dma_in_set) && !(m_burst && i == m_held)) dhit = 1;
      end
    end
    req_ok   = req_in_valid && nfree > 0 && !rhit && !m_burst;
    dma_ok   = dma_in_valid && nfree > 0 && !dhit;
    can_load = !m_sv || sel_ready;
    g = 0;
    if (can_load) begin
      if (rsp_in_valid)        g = 1;
      else if (req_ok && dma_ok) g = m_fav;
      else if (req_ok)         g = 2;
      else if (dma_ok)         g = 3;
    end
    chk("rsp_in_ready", rsp_in_ready, (g == 1) ? 1 : 0);
    chk("req_in_ready", req_in_ready, (g == 2) ? 1 : 0);
    chk("dma_in_ready", dma_in_ready, (g == 3) ? 1 : 0);
    last_rsp = rsp_in_ready; last_req = req_in_ready; last_dma = dma_in_ready;
    if ((req_in_valid && !m_burst && (nfree == 0 || rhit)) ||
        (dma_in_valid && (nfree == 0 || dhit)))
      if (m_stall < 65535) m_stall++;
    d_v = done_valid; d_i = int'(done_idx);
    @(posedge clk);
    if (d_v) m_vld[d_i] = 0;
    if (can_load) m_sv = (g != 0);
    case (g)
      1: begin m_sch = 1; m_sset = int'(rsp_in_set); m_sidx = 0; end
      2: begin
        m_sch = 2; m_sset = int'(req_in_set); m_sidx = lf;
        m_vld[lf] = 1; m_set[lf] = int'(req_in_set); m_fav = 3;
      end
      3: begin
        if (m_burst) alloc = m_held;
        else begin alloc = lf; m_vld[lf] = 1; m_set[lf] = int'(dma_in_set); end
        m_sch = 3; m_sset = int'(dma_in_set); m_sidx = alloc; m_fav = 2;
        if (dma_in_last) m_burst = 0;
        else begin m_burst = 1; m_held = alloc; end
      end
      default: ;
    endcase
    @(negedge clk);
  endtask

  int seq [4];
  int first_idx;

  initial begin
    idle_inputs();
    rst = 0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Response beats request; request follows next cycle with lock 0.
    rsp_in_valid = 1; rsp_in_set = 9'h05;
    req_in_valid = 1; req_in_set = 9'h10;
    step();
    chk("t1_rsp_ready", last_rsp, 1);
    chk("t1_rsp_ch", sel_ch, 1);
    chk("t1_rsp_set", sel_set, 9'h05);
    rsp_in_valid = 0;
    step();
    chk("t1_req_ready", last_req, 1);
    chk("t1_req_ch", sel_ch, 2);
    chk("t1_req_idx", sel_lock_idx, 0);
    do_reset();

    // Set conflict held until release; grant one cycle after the done edge.
    req_in_valid = 1; req_in_set = 9'h20;
    step();
    chk("t2_first_ready", last_req, 1);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t2_blocked", last_req, 0);
    end
    done_valid = 1; done_idx = 0;
    step();
    chk("t2_done_cycle_blocked", last_req, 0);
    done_valid = 0;
    step();
    chk("t2_after_done_ready", last_req, 1);
    chk("t2_after_done_idx", sel_lock_idx, 0);
    req_in_valid = 0;
    do_reset();

    // req/dma round-robin alternation from reset.
    for (int k = 0; k < 4; k++) begin
      req_in_valid = 1; req_in_set = 9'(9'h40 + k);
      dma_in_valid = 1; dma_in_set = 9'(9'h80 + k); dma_in_last = 1;
      done_valid = sel_valid; done_idx = sel_lock_idx;
      step();
      seq[k] = int'(sel_ch);
    end
    chk("t3_seq0", seq[0], 2);
    chk("t3_seq1", seq[1], 3);
    chk("t3_seq2", seq[2], 2);
    chk("t3_seq3", seq[3], 3);
    do_reset();

    // Three-beat DMA burst keeps its lock; req waits for the last beat.
    dma_in_valid = 1; dma_in_set = 9'h33; dma_in_last = 0;
    step();
    chk("t4_beat1_ch", sel_ch, 3);
    first_idx = int'(sel_lock_idx);
    req_in_valid = 1; req_in_set = 9'h50;
    for (int k = 0; k < 2; k++) begin
      dma_in_last = (k == 1);
      step();
      chk("t4_beat_ch", sel_ch, 3);
      chk("t4_beat_idx", sel_lock_idx, first_idx);
      chk("t4_req_held_off", last_req, 0);
    end
    dma_in_valid = 0;
    step();
    chk("t4_req_after_burst", last_req, 1);
    chk("t4_req_idx", sel_lock_idx, 1);
    req_in_valid = 0;
    do_reset();

    // Full lock table: only responses get through.
    for (int k = 1; k <= 4; k++) begin
      req_in_valid = 1; req_in_set = 9'(k);
      step();
      chk("t5_fill_idx", sel_lock_idx, k - 1);
    end
    req_in_set = 9'h5;
    rsp_in_valid = 1; rsp_in_set = 9'h1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t5_req_blocked", last_req, 0);
      chk("t5_rsp_granted", last_rsp, 1);
    end
    chk("t5_rsp_set", sel_set, 1);
`ifdef LLC_SCHED_STATS_EN
    chk("t5_stall_cnt", stall_cnt, 3);
`endif
    rsp_in_valid = 0; req_in_valid = 0;

    // Reset in the middle of a burst discards the lock.
    do_reset();
    dma_in_valid = 1; dma_in_set = 9'h33; dma_in_last = 0;
    step();
    step();
    do_reset();
    req_in_valid = 1; req_in_set = 9'h33;
    step();
    chk("t6_req_ready", last_req, 1);
    chk("t6_req_ch", sel_ch, 2);
    chk("t6_req_idx", sel_lock_idx, 0);
    req_in_valid = 0;
    do_reset();

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      rsp_in_valid = ($urandom_range(0, 99) < 20);
      req_in_valid = ($urandom_range(0, 99) < 60);
      dma_in_valid = ($urandom_range(0, 99) < 50);
      dma_in_last  = ($urandom_range(0, 99) < 40);
      rsp_in_set   = 9'($urandom_range(0, 5));
      req_in_set   = 9'($urandom_range(0, 5));
      dma_in_set   = 9'($urandom_range(0, 5));
      sel_ready    = ($urandom_range(0, 99) < 70);
      done_valid   = ($urandom_range(0, 99) < 35);
      done_idx     = 2'($urandom_range(0, 3));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
